// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: counter encodings, mode
// constants and the PC field / counter helper functions.
package bp_pkg;

  // 2-bit bimodal counter states; bit 1 is the taken/not-taken prediction.
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam int MODE_STATIC  = 0;
  localparam int MODE_BIMODAL = 1;

  // Helpers work on a 64-bit view of the PC so any XLEN up to 64 fits.
  localparam int unsigned BP_PC_W = 64;

  // Table index: pc[idx_w+1:2], returned right-aligned.
  function automatic logic [BP_PC_W-1:0] bp_idx(input logic [BP_PC_W-1:0] pc,
                                                input int unsigned idx_w);
    logic [BP_PC_W-1:0] mask;
    mask = (64'd1 << idx_w) - 64'd1;
    return (pc >> 32'd2) & mask;
  endfunction

  // Tag: pc[idx_w+tag_w+1:idx_w+2], returned right-aligned.
  function automatic logic [BP_PC_W-1:0] bp_tag(input logic [BP_PC_W-1:0] pc,
                                                input int unsigned idx_w,
                                                input int unsigned tag_w);
    logic [BP_PC_W-1:0] mask;
    mask = (64'd1 << tag_w) - 64'd1;
    return (pc >> (idx_w + 32'd2)) & mask;
  endfunction

  // Saturating step: up on taken, down on not-taken, clamped at SNT/ST.
  function automatic ctr_e sat_update(input ctr_e ctr, input logic taken);
    ctr_e nxt;
    case (ctr)
      CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
      default: nxt = CTR_WNT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, EX resolve/train and statistics signals of the predictor.
interface branch_predictor_if #(
  parameter int XLEN   = 32,
  parameter int STAT_W = 32
);
  logic              lookup_pc_dummy_unused_guard;
  logic [XLEN-1:0]   lookup_pc;
  logic              pred_taken;
  logic [XLEN-1:0]   pred_target;
  logic              upd_valid;
  logic [XLEN-1:0]   upd_pc;
  logic              upd_taken;
  logic [XLEN-1:0]   upd_target;
  logic              upd_pred_taken;
  logic [XLEN-1:0]   upd_pred_target;
  logic              mispredict;
  logic [XLEN-1:0]   recover_pc;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispredicts;

  // Pipeline side: drives fetch PC and resolved outcomes.
  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_target, mispredict, recover_pc,
           stat_branches, stat_mispredicts
  );

  // Predictor side.
  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    output pred_taken, pred_target, mispredict, recover_pc,
           stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count events, holding once the maximum value is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + bimodal BHT predictor beside IF, trained from EX.
// Lookup and resolve are combinational; training lands at the clock edge,
// so a same-cycle lookup of the entry being trained sees the old contents.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int MODE    = 1,
  parameter int STAT_W  = 32
) (
  input logic clk,
  input logic rst,
  branch_predictor_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  // Only valid bits and counters are reset; tag/target payload is not.
  logic [ENTRIES-1:0] valid_r;
  logic [1:0]         ctr_r    [ENTRIES];
  logic [TAG_W-1:0]   tag_r    [ENTRIES];
  logic [XLEN-1:0]    target_r [ENTRIES];

  logic [IDX_W-1:0] lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic             lk_hit_s;
  logic             pred_taken_s;
  logic [XLEN-1:0]  pred_target_s;

  logic [IDX_W-1:0] up_idx_s;
  logic [TAG_W-1:0] up_tag_s;
  logic             up_hit_s;
  logic             train_s;
  logic             mispredict_s;
  logic [XLEN-1:0]  recover_pc_s;

  // ---------------- lookup ----------------
  assign lk_idx_s = IDX_W'(bp_idx(BP_PC_W'(bus.lookup_pc), IDX_W));
  assign lk_tag_s = TAG_W'(bp_tag(BP_PC_W'(bus.lookup_pc), IDX_W, TAG_W));
  assign lk_hit_s = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);

  // Predict taken only on a tag hit with a taken-leaning counter.
  always_comb begin
    pred_taken_s = 1'b0;
    if (MODE == MODE_BIMODAL) begin
      pred_taken_s = lk_hit_s && ctr_r[lk_idx_s][1];
    end else begin
      pred_taken_s = 1'b0;
    end
  end

  // Next fetch PC: stored target when predicted taken, else fall through.
  always_comb begin
    pred_target_s = bus.lookup_pc + PC_STEP;
    if (pred_taken_s) begin
      pred_target_s = target_r[lk_idx_s];
    end else begin
      pred_target_s = bus.lookup_pc + PC_STEP;
    end
  end

  // ---------------- resolve ----------------
  // Redirect on wrong direction, or right direction with wrong target.
  always_comb begin
    mispredict_s = 1'b0;
    if (MODE == MODE_BIMODAL) begin
      mispredict_s = bus.upd_valid &&
                     ((bus.upd_taken != bus.upd_pred_taken) ||
                      (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));
    end else begin
      mispredict_s = bus.upd_valid && bus.upd_taken;
    end
  end

  // Correct next PC; only meaningful while mispredict is high.
  always_comb begin
    recover_pc_s = bus.upd_pc + PC_STEP;
    if (bus.upd_taken) begin
      recover_pc_s = bus.upd_target;
    end else begin
      recover_pc_s = bus.upd_pc + PC_STEP;
    end
  end

  // ---------------- training ----------------
  assign up_idx_s = IDX_W'(bp_idx(BP_PC_W'(bus.upd_pc), IDX_W));
  assign up_tag_s = TAG_W'(bp_tag(BP_PC_W'(bus.upd_pc), IDX_W, TAG_W));
  assign up_hit_s = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);
  assign train_s  = (MODE == MODE_BIMODAL) && bus.upd_valid;

  // Valid/counter state: step counter on hit, allocate at WT on taken miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i] <= 1'b0;
        ctr_r[i]   <= CTR_WNT;
      end
    end else if (train_s) begin
      if (up_hit_s) begin
        ctr_r[up_idx_s] <= sat_update(ctr_e'(ctr_r[up_idx_s]), bus.upd_taken);
      end else if (bus.upd_taken) begin
        valid_r[up_idx_s] <= 1'b1;
        ctr_r[up_idx_s]   <= CTR_WT;
      end else begin
        valid_r[up_idx_s] <= valid_r[up_idx_s];
      end
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag/target payload: written on every taken training event. A write
  // coincident with reset is harmless because the valid bit is cleared.
  always_ff @(posedge clk) begin
    if (train_s && bus.upd_taken) begin
      target_r[up_idx_s] <= bus.upd_target;
      tag_r[up_idx_s]    <= up_tag_s;
    end
  end

  // ---------------- statistics ----------------
  sat_counter #(.W(STAT_W)) u_stat_branches (
    .clk   (clk),
    .rst   (rst),
    .inc   (bus.upd_valid),
    .count (bus.stat_branches)
  );

  sat_counter #(.W(STAT_W)) u_stat_mispredicts (
    .clk   (clk),
    .rst   (rst),
    .inc   (mispredict_s),
    .count (bus.stat_mispredicts)
  );

  assign bus.pred_taken  = pred_taken_s;
  assign bus.pred_target = pred_target_s;
  assign bus.mispredict  = mispredict_s;
  assign bus.recover_pc  = recover_pc_s;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor that sits beside the IF stage of the 5-stage RISC-V pipeline.
- Indexed by PCF, it supplies a predicted next PC from a direct-mapped BTB with 2-bit saturating counters.
- It is trained from the EX stage with resolved branch/jump outcomes.
- Detects mispredictions, supplies the recovery PC for the PC mux and flush logic, and keeps saturating performance counters.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 64, BTB/BHT entry count; power of two, >= 2; IDX_W = log2(ENTRIES).
- TAG_W, 8, tag bits stored per entry.
- MODE, 1, 0 = static not-taken, 1 = bimodal dynamic.
- STAT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- lookup_pc  in  XLEN  fetch PC (PCF)
- pred_taken  out  1  prediction for lookup_pc
- pred_target  out  XLEN  predicted next PC
- upd_valid  in  1  a branch/jump resolved in EX this cycle; upstream deasserts it when EX is flushed
- upd_pc  in  XLEN  PC of the resolving instruction (PCE)
- upd_taken  in  1  actual outcome
- upd_target  in  XLEN  actual target (PCTargetE or ALUResultE)
- upd_pred_taken  in  1  prediction made at fetch, carried down the pipe
- upd_pred_target  in  XLEN  predicted next PC carried down the pipe
- mispredict  out  1  EX-stage redirect request
- recover_pc  out  XLEN  correct next PC on mispredict
- stat_branches  out  STAT_W  resolved branch count
- stat_mispredicts  out  STAT_W  mispredict count

Behaviour:
- Address fields:
  - idx = pc[IDX_W+1:2].
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Entry state: valid (1), tag (TAG_W), target (XLEN), ctr (2).
  - Counter encodings: 00 SNT, 01 WNT, 10 WT, 11 ST.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag match.
  - pred_taken = (MODE==1) && hit && ctr[1].
  - pred_target = pred_taken ? target[idx] : lookup_pc+4.
- Resolve (combinational):
  - mispredict = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)).
  - recover_pc = upd_taken ? upd_target : upd_pc+4, valid only while mispredict=1.
- Update, at posedge when upd_valid=1 and MODE==1:
  - Hit: ctr saturating +1 if taken, -1 if not taken. If taken, target is overwritten with upd_target.
  - Miss, taken: allocate entry with valid=1, tag, target=upd_target, ctr=10 (WT). A valid entry with a different tag is evicted.
  - Miss, not taken: no allocation, no state change.
- Saturation: ctr 11 + taken stays 11; ctr 00 + not-taken stays 00.
- Same-cycle lookup and update to the same idx: lookup returns pre-update contents. The new state is visible the next cycle; there is no bypass.
- MODE==0: tables are never written; pred_taken=0; pred_target=lookup_pc+4; mispredict reduces to upd_valid && upd_taken.
- Statistics, at posedge:
  - stat_branches increments when upd_valid=1.
  - stat_mispredicts increments when mispredict=1.
  - Both saturate at all-ones and never wrap.
- Stalls do not gate updates: each resolved instruction presents upd_valid exactly once.
- Reset (asynchronous, effective immediately, including mid-operation):
  - All valid bits cleared; all ctr set to 01; stats set to 0.
  - Tag/target storage is not reset.
  - Resulting outputs: pred_taken=0, pred_target=lookup_pc+4, mispredict follows its inputs.
  - An update coincident with reset is discarded.
- Arithmetic: +4 is modulo 2^XLEN; 0xFFFFFFFC + 4 = 0x00000000.

Decomposition:
- Shared package bp_pkg holds:
  - counter encodings SNT/WNT/WT/ST;
  - MODE_STATIC/MODE_BIMODAL constants;
  - functions bp_idx(pc) and bp_tag(pc);
  - function sat_update(ctr, taken).
- One sub-module, sat_counter: parametrised-width saturating event counter with asynchronous active-high reset, instantiated twice for the statistics.

Test Plan:
- Reset, lookup_pc=0x40 -> pred_taken=0, pred_target=0x44, stat_branches=0, stat_mispredicts=0.
- Taken update:
  - Stimulus: upd_valid=1, upd_pc=0x40, upd_taken=1, upd_target=0x20, upd_pred_taken=0.
  - Same cycle: mispredict=1, recover_pc=0x20.
  - Next cycle, lookup 0x40: pred_taken=1, pred_target=0x20.
  - Stats: 1/1.
- Counter walk on 0x40 (starting from WT):
  - NT update -> ctr 01, pred_taken=0.
  - 2× T -> 11.
  - T -> stays 11.
  - NT -> 10, still pred_taken=1.
- Aliasing (ENTRIES=64): after allocating 0x40, lookup 0x140 (same idx, different tag) -> pred_taken=0, pred_target=0x144. A taken update at 0x140 evicts 0x40; 0x40 then misses.
- Same-cycle lookup and update on 0x40 (first taken update) -> lookup that cycle pred_taken=0; the next cycle shows 1.
- Reset and static mode:
  - Assert rst between clock edges after training -> pred_taken drops immediately and stats read 0.
  - MODE=0 -> pred_taken always 0; 3 taken + 2 not-taken updates give stat_branches=5, stat_mispredicts=3.
